car_lane_driver: RTL and testbench
==================================

// Module: car_lane_driver
// PURPOSE
//   Generates the horizontal positions of the eight road cars (car_x1..car_x8) consumed by
//   the player movement/collision stage. Each lane has its own prescaler and moves a fixed
//   pixel step per period, in an alternating direction, wrapping around the visible width.
//   A difficulty level shortens all periods; RUN freezes the road (pause / game over).
// PARAMETERS
//   H_DISPLAY    640      visible width in pixels; positions are kept in [0, H_DISPLAY-1]
//   STEP         4        pixels moved per lane step; 1 <= STEP < H_DISPLAY
//   BASE_PERIOD  400000   CLK cycles per step for a multiplier-1 lane at level 0 (>= 16)
//   INIT_SPACING 80       reset position of lane k = (k-1)*INIT_SPACING, k = 1..8
// PORTS
//   CLK         in   1   system clock
//   RST         in   1   synchronous reset, active-high
//   RUN         in   1   1 = cars move; 0 = counters and positions hold
//   level       in   2   difficulty 0..3; lane period = (BASE_PERIOD*M_k) >> level
//   car_x1..8   out  10  registered x position of lanes 1..8
//   car_step    out  8   bit k-1 pulses high 1 cycle when lane k moves
// BEHAVIOUR
//   Interface: one clock CLK; RST is synchronous and active-high.
//   Reset (RST=1 at a CLK edge): car_xk <= (k-1)*INIT_SPACING, all prescalers <= 0,
//     car_step <= 0. Overrides RUN/level; reset mid-period discards the partial count.
//   Multipliers M_k = {1,2,3,4,1,2,3,4} for lanes 1..8. LIMIT_k = ((BASE_PERIOD*M_k)>>level)-1,
//     computed combinationally from the live level; prescaler width >= 32 bits.
//   Direction: odd lanes (1,3,5,7) move right (+STEP); even lanes move left (-STEP).
//   Per lane, each CLK edge with RST=0:
//     RUN=0: prescaler, car_xk hold; car_step bit <= 0.
//     RUN=1, cnt_k <  LIMIT_k: cnt_k <= cnt_k+1; car_step bit <= 0.
//     RUN=1, cnt_k >= LIMIT_k: cnt_k <= 0; car_xk <= next_k; car_step bit <= 1.
//   The >= compare is required: if level rises mid-count so that cnt_k already exceeds
//     the new LIMIT_k, the lane steps on the next RUN=1 edge and restarts from 0.
//   Wrap (modular, no lost pixels; arithmetic done in 11 bits):
//     right: s = x+STEP; next = (s >= H_DISPLAY) ? s-H_DISPLAY : s.
//     left : next = (x < STEP) ? x+H_DISPLAY-STEP : x-STEP.
//   Latency: new car_xk and its car_step bit become visible together, same edge.
//   Lanes are independent; several lanes may step on the same edge.
//   Positions never leave [0, H_DISPLAY-1].
//   No combinational path from any input to any output.
// TESTING (bench: BASE_PERIOD=4, STEP=4, H_DISPLAY=640, INIT_SPACING=80)
//   1. RST=1 for 2 cycles -> car_x1..8 = 0,80,160,240,320,400,480,560; car_step=0.
//   2. RUN=1, level=0, 4 edges after reset -> car_x1=4, car_step[0]=1 for that cycle;
//      car_x2 steps (to 76) at edge 8; car_x4 steps (to 236) at edge 16.
//   3. Wrap: car_x1=636 stepping -> 0; car_x2=0 stepping -> 636; car_x3=638 -> 2.
//   4. level=2 -> lane 1 period 1 cycle (steps every edge), lane 4 period 4 cycles;
//      level 0->3 with cnt_4=10 -> lane 4 steps on next edge, cnt_4=0.
//   5. RUN=0 for 20 cycles mid-period -> positions, counters frozen, car_step=0;
//      RUN=1 resumes from the held count (no extra or lost step).
//   6. RST asserted mid-run with RUN=1 -> next edge restores reset positions; first
//      step of lane 1 occurs exactly 4 edges after RST deasserts.

Source files
------------

// File: rtl/car_lane_driver_if.sv
// car_lane_driver_if
//   Groups the road-control inputs and the per-lane position outputs of
//   car_lane_driver. The clock and reset are kept as plain module ports.
//   Signals:
//     RUN        game controller -> driver : 1 = cars move, 0 = road frozen
//     level      game controller -> driver : difficulty 0..3
//     car_x1..8  driver -> consumer        : registered lane x positions
//     car_step   driver -> consumer        : bit k-1 pulses when lane k moves
//   Modports:
//     master : the game controller / collision stage side
//     slave  : the lane driver itself
interface car_lane_driver_if;
  logic       RUN;
  logic [1:0] level;
  logic [9:0] car_x1;
  logic [9:0] car_x2;
  logic [9:0] car_x3;
  logic [9:0] car_x4;
  logic [9:0] car_x5;
  logic [9:0] car_x6;
  logic [9:0] car_x7;
  logic [9:0] car_x8;
  logic [7:0] car_step;

  modport master (
    output RUN, level,
    input  car_x1, car_x2, car_x3, car_x4,
    input  car_x5, car_x6, car_x7, car_x8,
    input  car_step
  );

  modport slave (
    input  RUN, level,
    output car_x1, car_x2, car_x3, car_x4,
    output car_x5, car_x6, car_x7, car_x8,
    output car_step
  );
endinterface

// File: rtl/car_lane_driver.sv
// car_lane_driver
//   Generates the horizontal positions of the eight road cars. Every lane has
//   its own prescaler; when it reaches its terminal count the lane moves STEP
//   pixels (odd lanes right, even lanes left), wrapping modulo H_DISPLAY.
//   Lane period = (BASE_PERIOD * M_k) >> level with M = {1,2,3,4,1,2,3,4}.
//   Ports:
//     CLK  in  system clock
//     RST  in  synchronous reset, active-high
//     bus  car_lane_driver_if.slave (RUN, level in; car_x1..8, car_step out)
//   All outputs are registered; there is no input-to-output combinational path.
module car_lane_driver #(
  parameter int H_DISPLAY    = 640,
  parameter int STEP         = 4,
  parameter int BASE_PERIOD  = 400000,
  parameter int INIT_SPACING = 80
) (
  input  logic               CLK,
  input  logic               RST,
  car_lane_driver_if.slave   bus
);

  localparam int          NUM_LANES = 8;
  localparam logic [31:0] BASE_W    = 32'(BASE_PERIOD);
  localparam logic [10:0] H_W       = 11'(H_DISPLAY);
  localparam logic [10:0] STEP_W    = 11'(STEP);

  logic [9:0]  pos_q    [NUM_LANES];
  logic [31:0] cnt_q    [NUM_LANES];
  logic [7:0]  step_q;

  logic [31:0] limit    [NUM_LANES];
  logic [9:0]  next_pos [NUM_LANES];
  logic [7:0]  hit;

  // Terminal counts, next positions and terminal-count hits, all from the
  // live level so a level change takes effect on the very next edge.
  always_comb begin
    logic [31:0] period;
    logic [10:0] x_ext;
    logic [10:0] sum;
    period = '0;
    x_ext  = '0;
    sum    = '0;
    hit    = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      limit[k]    = '0;
      next_pos[k] = '0;
    end

    for (int k = 0; k < NUM_LANES; k++) begin
      period = (BASE_W * 32'((k % 4) + 1)) >> bus.level;
      // A shifted-to-zero period would underflow; treat it as "step every edge".
      limit[k] = (period == '0) ? '0 : period - 32'd1;
      // >= so that a level increase past the current count steps immediately.
      hit[k]   = (cnt_q[k] >= limit[k]);

      x_ext = {1'b0, pos_q[k]};
      if ((k % 2) == 0) begin
        sum         = x_ext + STEP_W;
        next_pos[k] = 10'((sum >= H_W) ? sum - H_W : sum);
      end else begin
        next_pos[k] = 10'((x_ext < STEP_W) ? x_ext + H_W - STEP_W
                                           : x_ext - STEP_W);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        pos_q[k] <= 10'(k * INIT_SPACING);
        cnt_q[k] <= '0;
      end
      step_q <= '0;
    end else if (!bus.RUN) begin
      step_q <= '0;
    end else begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (hit[k]) begin
          cnt_q[k] <= '0;
          pos_q[k] <= next_pos[k];
        end else begin
          cnt_q[k] <= cnt_q[k] + 32'd1;
        end
      end
      step_q <= hit;
    end
  end

  assign bus.car_x1   = pos_q[0];
  assign bus.car_x2   = pos_q[1];
  assign bus.car_x3   = pos_q[2];
  assign bus.car_x4   = pos_q[3];
  assign bus.car_x5   = pos_q[4];
  assign bus.car_x6   = pos_q[5];
  assign bus.car_x7   = pos_q[6];
  assign bus.car_x8   = pos_q[7];
  assign bus.car_step = step_q;

endmodule

// File: tb/tb_car_lane_driver.sv
// tb_car_lane_driver
//   Drives car_lane_driver with directed phases followed by random RST/RUN/level
//   traffic. A reference model of the road (elapsed-cycle counters and modular
//   positions) predicts each post-edge output set, which is queued and compared
//   by an independent monitor one time unit after every rising edge.
module tb_car_lane_driver;

  localparam int H    = 640;
  localparam int STP  = 4;
  localparam int BASE = 4;
  localparam int SPC  = 80;

  logic CLK = 1'b0;
  logic RST;
  car_lane_driver_if bus();

  car_lane_driver #(
    .H_DISPLAY(H), .STEP(STP), .BASE_PERIOD(BASE), .INIT_SPACING(SPC)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  // Reference model state.
  int  m_x    [8];
  int  m_el   [8];
  bit  [7:0] m_step;
  logic [87:0] exp_q [$];

  int compared   = 0;
  int mismatched = 0;
  int cycle_no   = 0;

  // One rising edge of the road as described in words: a running lane
  // accumulates elapsed cycles and moves once its period's worth has passed.
  task automatic model_edge(input bit rst, input bit run, input int lvl);
    int period;
    for (int k = 0; k < 8; k++) begin
      if (rst) begin
        m_x[k]    = k * SPC;
        m_el[k]   = 0;
        m_step[k] = 1'b0;
      end else if (!run) begin
        m_step[k] = 1'b0;
      end else begin
        period = (BASE * ((k % 4) + 1)) / (1 << lvl);
        if (period < 1) period = 1;
        if (m_el[k] + 1 >= period) begin
          m_el[k]   = 0;
          m_x[k]    = (m_x[k] + ((k % 2 == 0) ? STP : -STP) + H) % H;
          m_step[k] = 1'b1;
        end else begin
          m_el[k]   = m_el[k] + 1;
          m_step[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic cyc(input bit rst, input bit run, input int lvl);
    logic [87:0] e;
    RST       = rst;
    bus.RUN   = run;
    bus.level = 2'(lvl);
    model_edge(rst, run, lvl);
    e = '0;
    for (int k = 0; k < 8; k++) e[87 - 10*k -: 10] = 10'(m_x[k]);
    e[7:0] = m_step;
    exp_q.push_back(e);
    @(negedge CLK);
  endtask

  // Monitor: every post-edge sample is checked against the oldest prediction.
  initial begin
    logic [87:0] act, e;
    forever begin
      @(posedge CLK);
      #1;
      cycle_no++;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {bus.car_x1, bus.car_x2, bus.car_x3, bus.car_x4,
               bus.car_x5, bus.car_x6, bus.car_x7, bus.car_x8, bus.car_step};
        compared++;
        if (act !== e) begin
          mismatched++;
          $display("FAIL lanes cycle %0d: got x=%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d step=%b want x=%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d step=%b",
                   cycle_no,
                   act[87:78], act[77:68], act[67:58], act[57:48],
                   act[47:38], act[37:28], act[27:18], act[17:8], act[7:0],
                   e[87:78], e[77:68], e[67:58], e[57:48],
                   e[47:38], e[37:28], e[27:18], e[17:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    RST       = 1'b1;
    bus.RUN   = 1'b0;
    bus.level = 2'd0;

    // Reset for two cycles, then plain running long enough for lanes 1 and 2 to wrap.
    repeat (2)   cyc(1, 0, 0);
    repeat (700) cyc(0, 1, 0);

    // Fresh count, ten cycles in, then jump to level 3 (lane 4 overshoots its limit).
    cyc(1, 0, 0);
    repeat (10) cyc(0, 1, 0);
    repeat (6)  cyc(0, 1, 3);
    repeat (20) cyc(0, 1, 2);

    // Freeze mid-period, then resume.
    repeat (5)  cyc(0, 1, 0);
    repeat (20) cyc(0, 0, 0);
    repeat (30) cyc(0, 1, 0);

    // Reset while running; lane 1 first steps four edges after release.
    repeat (3)  cyc(0, 1, 0);
    cyc(1, 1, 0);
    repeat (12) cyc(0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 7) != 0),
          int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge CLK);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending predictions want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
